// File: rtl/rgb_hsv_pkg.sv
// Shared constants and types for the RGB -> HSV converter.
package rgb_hsv_pkg;

    localparam int CH_W       = 8;
    localparam int HUE_W      = 9;
    localparam int HUE_SECTOR = 60;
    localparam int HUE_FULL   = 360;
    localparam int HUE_G_BASE = 120;
    localparam int HUE_B_BASE = 240;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } max_sel_t;

endpackage

// File: rtl/rgb_hsv_div.sv
// Combinational 16-bit / 8-bit unsigned divider with saturated 8-bit quotient; divide by 0 yields 0.
// Define RGB2HSV_ROUND_EN to round to nearest (half up) instead of truncating.
module rgb_hsv_div
    import rgb_hsv_pkg::*;
#(
    parameter logic [7:0] Q_MAX = 8'd255
) (
    input  logic [15:0] num,
    input  logic [7:0]  den,
    output logic [7:0]  q
);

    logic [16:0] num_adj;
    logic [16:0] quot;

    function automatic logic [7:0] sat_q(input logic [16:0] x);
        return (x > 17'(Q_MAX)) ? Q_MAX : x[7:0];
    endfunction

    always_comb begin
`ifdef RGB2HSV_ROUND_EN
        num_adj = {1'b0, num} + 17'(den >> 1);
`else
        num_adj = {1'b0, num};
`endif
        quot = (den == 8'd0) ? 17'd0 : num_adj / 17'(den);
        q    = sat_q(quot);
    end

endmodule

// File: rtl/rgb_to_hsv.sv
// Three-stage pipelined RGB -> HSV converter: compare, divide, hue assembly.
// Optional build macro RGB2HSV_ROUND_EN selects round-to-nearest divides.
module rgb_to_hsv
    import rgb_hsv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_W-1:0]   r,
    input  logic [CH_W-1:0]   g,
    input  logic [CH_W-1:0]   b,
    output logic [HUE_W-1:0]  h,
    output logic [CH_W-1:0]   s,
    output logic [CH_W-1:0]   v
);

    logic [CH_W-1:0]        max_p1_d, max_p1_q, delta_p1_d, delta_p1_q, min_c;
    logic signed [CH_W:0]   d_p1_d, d_p1_q;
    max_sel_t               sel_p1_d, sel_p1_q;

    logic [CH_W-1:0]        max_p2_d, max_p2_q, delta_p2_d, delta_p2_q;
    logic [CH_W-1:0]        qs_p2_d, qs_p2_q, qh_p2_d, qh_p2_q, dabs;
    logic                   dneg_p2_d, dneg_p2_q;
    max_sel_t               sel_p2_d, sel_p2_q;
    logic [15:0]            num_s, num_h;

    logic [HUE_W-1:0]       h_d, h_q, base, qh9, hue;
    logic [CH_W-1:0]        s_d, s_q, v_d, v_q;

    // Stage 1: max/min compare, max-channel select (ties favour r, then g), signed hue numerator
    always_comb begin
        min_c = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
        if (r >= g && r >= b) begin
            sel_p1_d = SEL_R;
            max_p1_d = r;
            d_p1_d   = $signed({1'b0, g}) - $signed({1'b0, b});
        end else if (g >= b) begin
            sel_p1_d = SEL_G;
            max_p1_d = g;
            d_p1_d   = $signed({1'b0, b}) - $signed({1'b0, r});
        end else begin
            sel_p1_d = SEL_B;
            max_p1_d = b;
            d_p1_d   = $signed({1'b0, r}) - $signed({1'b0, g});
        end
        delta_p1_d = max_p1_d - min_c;
    end

    // Stage 2: saturation and hue-offset divides
    always_comb begin
        dabs       = d_p1_q[CH_W] ? CH_W'(-d_p1_q) : d_p1_q[CH_W-1:0];
        num_s      = 16'(delta_p1_q) * 16'd255;
        num_h      = 16'(dabs) * 16'(HUE_SECTOR);
        max_p2_d   = max_p1_q;
        delta_p2_d = delta_p1_q;
        sel_p2_d   = sel_p1_q;
        dneg_p2_d  = d_p1_q[CH_W];
    end

    rgb_hsv_div #(.Q_MAX(8'd255)) u_div_s (
        .num (num_s),
        .den (max_p1_q),
        .q   (qs_p2_d)
    );

    rgb_hsv_div #(.Q_MAX(8'(HUE_SECTOR))) u_div_h (
        .num (num_h),
        .den (delta_p1_q),
        .q   (qh_p2_d)
    );

    // Stage 3: hue sector assembly; negative offsets from the red sector wrap around 360
    always_comb begin
        base = (sel_p2_q == SEL_G) ? HUE_W'(HUE_G_BASE) :
               (sel_p2_q == SEL_B) ? HUE_W'(HUE_B_BASE) : '0;
        qh9  = HUE_W'(qh_p2_q);
        hue  = '0;
        h_d  = '0;
        s_d  = '0;
        v_d  = max_p2_q;
        if (delta_p2_q != '0) begin
            s_d = qs_p2_q;
            if (!dneg_p2_q)
                hue = base + qh9;
            else if (qh9 > base)
                hue = base + HUE_W'(HUE_FULL) - qh9;
            else
                hue = base - qh9;
            h_d = (hue == HUE_W'(HUE_FULL)) ? '0 : hue;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_p1_q   <= '0;
            delta_p1_q <= '0;
            d_p1_q     <= '0;
            sel_p1_q   <= SEL_R;
            max_p2_q   <= '0;
            delta_p2_q <= '0;
            qs_p2_q    <= '0;
            qh_p2_q    <= '0;
            dneg_p2_q  <= 1'b0;
            sel_p2_q   <= SEL_R;
            h_q        <= '0;
            s_q        <= '0;
            v_q        <= '0;
        end else begin
            max_p1_q   <= max_p1_d;
            delta_p1_q <= delta_p1_d;
            d_p1_q     <= d_p1_d;
            sel_p1_q   <= sel_p1_d;
            max_p2_q   <= max_p2_d;
            delta_p2_q <= delta_p2_d;
            qs_p2_q    <= qs_p2_d;
            qh_p2_q    <= qh_p2_d;
            dneg_p2_q  <= dneg_p2_d;
            sel_p2_q   <= sel_p2_d;
            h_q        <= h_d;
            s_q        <= s_d;
            v_q        <= v_d;
        end
    end

    assign h = h_q;
    assign s = s_q;
    assign v = v_q;

endmodule

// File: tb/tb_rgb_to_hsv.sv
// Scoreboard bench for rgb_to_hsv: directed pixels, random stream, asynchronous reset pulse.
module tb_rgb_to_hsv;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] r, g, b;
    logic [8:0] h;
    logic [7:0] s, v;

    typedef struct packed {
        logic [8:0] h;
        logic [7:0] s;
        logic [7:0] v;
    } hsv_t;

    hsv_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    rgb_to_hsv dut (
        .clk (clk),
        .rst (rst),
        .r   (r),
        .g   (g),
        .b   (b),
        .h   (h),
        .s   (s),
        .v   (v)
    );

    always #5 clk = ~clk;

    function automatic hsv_t mk(input int hh, input int ss, input int vv);
        hsv_t o;
        o.h = 9'(hh);
        o.s = 8'(ss);
        o.v = 8'(vv);
        return o;
    endfunction

    // Floating-point reference: hue offset 60*|d|/delta, saturation 255*delta/max
    function automatic hsv_t model(input int ri, input int gi, input int bi);
        int  mx, mn, dl, base, qh, ss, hh;
        real num, mag;
        mx = (ri > gi) ? ri : gi;
        mx = (bi > mx) ? bi : mx;
        mn = (ri < gi) ? ri : gi;
        mn = (bi < mn) ? bi : mn;
        dl = mx - mn;
        if (ri >= gi && ri >= bi) begin
            base = 0;   num = real'(gi - bi);
        end else if (gi >= bi) begin
            base = 120; num = real'(bi - ri);
        end else begin
            base = 240; num = real'(ri - gi);
        end
        if (dl == 0) return mk(0, 0, mx);
        mag = (num < 0.0) ? -num : num;
`ifdef RGB2HSV_ROUND_EN
        ss = $rtoi(255.0 * real'(dl) / real'(mx) + 0.5);
        qh = $rtoi(60.0 * mag / real'(dl) + 0.5);
        if (qh > 60) qh = 60;
`else
        ss = $rtoi(255.0 * real'(dl) / real'(mx));
        qh = $rtoi(60.0 * mag / real'(dl));
`endif
        hh = (num < 0.0) ? base - qh : base + qh;
        if (hh < 0) hh = hh + 360;
        if (hh == 360) hh = 0;
        return mk(hh, ss, mx);
    endfunction

    task automatic check(input string tag, input hsv_t e);
        total++;
        assert ({h, s, v} === e) else begin
            bad++;
            $error("FAIL %s: got h=%0d s=%0d v=%0d, want h=%0d s=%0d v=%0d",
                   tag, h, s, v, e.h, e.s, e.v);
        end
    endtask

    // Called at a negedge: drive a pixel, clock it in, compare the pixel that emerges, return at next negedge
    task automatic step(input int ri, input int gi, input int bi, input hsv_t e, input string tag);
        r = 8'(ri);
        g = 8'(gi);
        b = 8'(bi);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 3) check(tag_q.pop_front(), exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic restart_queue();
        exp_q.delete();
        tag_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        tag_q.push_back("post_rst_0");
        tag_q.push_back("post_rst_1");
    endtask

    initial begin
        int ri, gi, bi;
        rst = 1'b1;
        r = 8'd200;
        g = 8'd13;
        b = 8'd77;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", '0);
        end
        @(negedge clk);
        rst = 1'b0;
        restart_queue();

        step(129, 88, 47, mk(30, 162, 129), "t2_orange");
`ifdef RGB2HSV_ROUND_EN
        step(122, 93, 46, mk(37, 159, 122), "t3_brown");
`else
        step(122, 93, 46, mk(37, 158, 122), "t3_brown");
`endif
        step(0, 0, 0,       mk(0, 0, 0),       "black");
        step(200, 200, 200, mk(0, 0, 200),     "grey");
        step(255, 255, 255, mk(0, 0, 255),     "white");
        step(255, 0, 0,     mk(0, 255, 255),   "red");
        step(0, 255, 0,     mk(120, 255, 255), "green");
        step(0, 0, 255,     mk(240, 255, 255), "blue");
        step(255, 0, 128,   mk(330, 255, 255), "wrap_330");
        step(255, 0, 1,     mk(0, 255, 255),   "wrap_360");
        step(255, 255, 0,   mk(60, 255, 255),  "tie_rg");
        step(0, 255, 255,   mk(180, 255, 255), "tie_gb");

        for (int i = 0; i < 150; i++) begin
            ri = int'($urandom_range(0, 255));
            gi = int'($urandom_range(0, 255));
            bi = int'($urandom_range(0, 255));
            if (i % 9 == 0) gi = ri;
            if (i % 13 == 0) bi = gi;
            step(ri, gi, bi, model(ri, gi, bi), "rand");
            if (i == 70) begin
                #2;
                rst = 1'b1;
                #1;
                check("async_rst", '0);
                @(posedge clk);
                #1;
                check("rst_pulse_hold", '0);
                @(negedge clk);
                rst = 1'b0;
                restart_queue();
            end
        end

        repeat (3) step(0, 0, 0, mk(0, 0, 0), "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
